// File: rtl/multicycle_control.sv
// Control unit for a multi-cycle MIPS-style datapath: a 12-state Moore FSM with
// mem_ready qualification on memory states, plus a retired-instruction counter.
module multicycle_control (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        pcwritecond_eq,
    output logic        pcwritecond_ne,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        irwrite,
    output logic        regdst,
    output logic        regwrite,
    output logic        alusrca,
    output logic        illegal_op,
    output logic [1:0]  pcsource,
    output logic [1:0]  alusrcb,
    output logic [1:0]  aluop,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    state_e      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        retire;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_d = S_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Gated by reset_n so outputs drop the instant reset asserts, not at the next edge.
    always_comb begin
        pcwrite        = 1'b0;
        pcwritecond_eq = 1'b0;
        pcwritecond_ne = 1'b0;
        iord           = 1'b0;
        memread        = 1'b0;
        memwrite       = 1'b0;
        memtoreg       = 1'b0;
        irwrite        = 1'b0;
        regdst         = 1'b0;
        regwrite       = 1'b0;
        alusrca        = 1'b0;
        illegal_op     = 1'b0;
        pcsource       = 2'b00;
        alusrcb        = 2'b00;
        aluop          = 2'b00;
        if (reset_n) begin
            unique case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                        OP_J, OP_ADDI, OP_ANDI: illegal_op = 1'b0;
                        default:                illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BRANCH: begin
                    alusrca        = 1'b1;
                    aluop          = 2'b01;
                    pcsource       = 2'b01;
                    pcwritecond_eq = (opcode == OP_BEQ);
                    pcwritecond_ne = (opcode == OP_BNE);
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                S_IEXEC: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
                end
                S_IWB: regwrite = 1'b1;
                default: ;
            endcase
        end
    end

    // An instruction retires in its final state; MEMWR only once memory completes.
    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: retire = 1'b1;
            S_MEMWR:                                 retire = mem_ready;
            default:                                 retire = 1'b0;
        endcase
        instr_count_d = instr_count_q + {31'd0, retire};
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: latency table, directed corner
// sequences and randomized instructions against a per-instruction step model.
module tb_multicycle_control;

    logic        clk;
    logic        reset_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pcwrite, pcwritecond_eq, pcwritecond_ne, iord, memread, memwrite;
    logic        memtoreg, irwrite, regdst, regwrite, alusrca, illegal_op;
    logic [1:0]  pcsource, alusrcb, aluop;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_control dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .opcode         (opcode),
        .mem_ready      (mem_ready),
        .pcwrite        (pcwrite),
        .pcwritecond_eq (pcwritecond_eq),
        .pcwritecond_ne (pcwritecond_ne),
        .iord           (iord),
        .memread        (memread),
        .memwrite       (memwrite),
        .memtoreg       (memtoreg),
        .irwrite        (irwrite),
        .regdst         (regdst),
        .regwrite       (regwrite),
        .alusrca        (alusrca),
        .illegal_op     (illegal_op),
        .pcsource       (pcsource),
        .alusrcb        (alusrcb),
        .aluop          (aluop),
        .state          (state),
        .instr_count    (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond_eq;
        logic       pcwritecond_ne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic       illegal_op;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        ctrl_t      c;
        logic       mr;
        bit         retire;
    } step_t;

    typedef struct {
        logic [5:0] op;
        int         lat;
        int         ret;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_count = 0;
    logic [5:0]  cur_op;
    step_t       steps[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic ctrl_t observed();
        ctrl_t c;
        c = {pcwrite, pcwritecond_eq, pcwritecond_ne, iord, memread, memwrite,
             memtoreg, irwrite, regdst, regwrite, alusrca, illegal_op,
             pcsource, alusrcb, aluop};
        return c;
    endfunction

    function automatic void push(input logic [3:0] st, input ctrl_t c, input logic mr, input bit ret);
        step_t s;
        s.st = st; s.c = c; s.mr = mr; s.retire = ret;
        steps.push_back(s);
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from the instruction-level rules.
    task automatic build_instr(input logic [5:0] op, input int fw, input int mw);
        ctrl_t c;
        steps.delete();
        cur_op = op;
        for (int i = 0; i <= fw; i++) begin
            c = '0; c.memread = 1; c.alusrcb = 2'b01;
            if (i == fw) begin c.irwrite = 1; c.pcwrite = 1; end
            push(4'd0, c, (i == fw), 0);
        end
        c = '0; c.alusrcb = 2'b11;
        case (op)
            6'b000000: begin
                push(4'd1, c, rnd_bit(), 0);
                c = '0; c.alusrca = 1; c.aluop = 2'b10; push(4'd6, c, rnd_bit(), 0);
                c = '0; c.regdst = 1; c.regwrite = 1;  push(4'd7, c, rnd_bit(), 1);
            end
            6'b100011: begin
                push(4'd1, c, rnd_bit(), 0);
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; push(4'd2, c, rnd_bit(), 0);
                c = '0; c.memread = 1; c.iord = 1;
                for (int i = 0; i <= mw; i++) push(4'd3, c, (i == mw), 0);
                c = '0; c.memtoreg = 1; c.regwrite = 1; push(4'd4, c, rnd_bit(), 1);
            end
            6'b101011: begin
                push(4'd1, c, rnd_bit(), 0);
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; push(4'd2, c, rnd_bit(), 0);
                c = '0; c.memwrite = 1; c.iord = 1;
                for (int i = 0; i <= mw; i++) push(4'd5, c, (i == mw), (i == mw));
            end
            6'b000100, 6'b000101: begin
                push(4'd1, c, rnd_bit(), 0);
                c = '0; c.alusrca = 1; c.aluop = 2'b01; c.pcsource = 2'b01;
                c.pcwritecond_eq = (op == 6'b000100);
                c.pcwritecond_ne = (op == 6'b000101);
                push(4'd8, c, rnd_bit(), 1);
            end
            6'b000010: begin
                push(4'd1, c, rnd_bit(), 0);
                c = '0; c.pcwrite = 1; c.pcsource = 2'b10; push(4'd9, c, rnd_bit(), 1);
            end
            6'b001000, 6'b001100: begin
                push(4'd1, c, rnd_bit(), 0);
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10;
                c.aluop = (op == 6'b001100) ? 2'b11 : 2'b00;
                push(4'd10, c, rnd_bit(), 0);
                c = '0; c.regwrite = 1; push(4'd11, c, rnd_bit(), 1);
            end
            default: begin
                c.illegal_op = 1;
                push(4'd1, c, rnd_bit(), 0);
            end
        endcase
    endtask

    // Drive each step for one cycle and compare mid-cycle, before the next rising edge.
    task automatic run_steps(input string tag, input int limit);
        for (int i = 0; i < steps.size() && i < limit; i++) begin
            @(negedge clk);
            opcode    = cur_op;
            mem_ready = steps[i].mr;
            #1;
            check({tag, "_state"}, {28'd0, state}, {28'd0, steps[i].st});
            check({tag, "_ctrl"}, {14'd0, observed()}, {14'd0, steps[i].c});
            check({tag, "_count"}, instr_count, exp_count);
            check({tag, "_excl"}, {30'd0, pcwrite & (pcwritecond_eq | pcwritecond_ne),
                                   memread & memwrite}, 32'd0);
            if (steps[i].retire) exp_count = exp_count + 32'd1;
        end
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input int fw, input int mw);
        build_instr(op, fw, mw);
        run_steps(tag, steps.size());
    endtask

    vec_t vecs[9];

    initial begin
        int          cyc;
        logic [31:0] start;
        logic [5:0]  legal[8];

        vecs[0] = '{6'b000000, 4, 1};
        vecs[1] = '{6'b100011, 5, 1};
        vecs[2] = '{6'b101011, 4, 1};
        vecs[3] = '{6'b000100, 3, 1};
        vecs[4] = '{6'b000101, 3, 1};
        vecs[5] = '{6'b000010, 3, 1};
        vecs[6] = '{6'b001000, 4, 1};
        vecs[7] = '{6'b001100, 4, 1};
        vecs[8] = '{6'b111111, 2, 0};
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000101, 6'b000010, 6'b001000, 6'b001100};

        reset_n   = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;

        @(negedge clk);
        #1;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_ctrl", {14'd0, observed()}, 32'd0);
        check("reset_count", instr_count, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        do_instr("rtype", 6'b000000, 0, 0);
        do_instr("lw_wait", 6'b100011, 0, 2);
        do_instr("bne", 6'b000101, 0, 0);
        do_instr("beq", 6'b000100, 0, 0);
        do_instr("illegal", 6'b111111, 0, 0);
        do_instr("fetch_wait", 6'b001100, 2, 0);

        for (int v = 0; v < 9; v++) begin
            cyc   = 0;
            start = exp_count;
            do begin
                @(negedge clk);
                opcode    = vecs[v].op;
                mem_ready = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
            end while (state !== 4'd0 && cyc < 20);
            check("latency", cyc, vecs[v].lat);
            check("latency_retire", instr_count - start, vecs[v].ret);
            exp_count = start + vecs[v].ret;
        end

        @(negedge clk);
        mem_ready = 1'b0;
        dut.instr_count_q = 32'hFFFF_FFFF;
        exp_count = 32'hFFFF_FFFF;
        do_instr("jump_wrap", 6'b000010, 0, 0);
        @(negedge clk);
        #1;
        check("wrap_zero", instr_count, 32'd0);
        mem_ready = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom()) : legal[$urandom_range(0, 7)];
            do_instr("rand", op, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        check("pre_reset_count_nonzero", {31'd0, instr_count != 32'd0}, 32'd1);
        build_instr(6'b101011, 0, 3);
        run_steps("sw_reset", 4);
        #1 reset_n = 1'b0;
        #1;
        check("async_memwrite", {31'd0, memwrite}, 32'd0);
        check("async_state", {28'd0, state}, 32'd0);
        check("async_count", instr_count, 32'd0);
        check("async_ctrl", {14'd0, observed()}, 32'd0);
        exp_count = 0;
        @(posedge clk);
        #1;
        check("held_ctrl", {14'd0, observed()}, 32'd0);
        check("held_state", {28'd0, state}, 32'd0);
        reset_n = 1'b1;
        do_instr("after_reset", 6'b101011, 0, 1);
        do_instr("after_reset2", 6'b001000, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge system clock.
REQ-002 SHALL have: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: opcode  input  6  IR[31:26]; stable from DECODE until the next FETCH.
REQ-004 SHALL have: mem_ready  input  1  memory completes the current read/write this cycle.
REQ-005 SHALL have outputs, 1 bit each: pcwrite, pcwritecond_eq, pcwritecond_ne, iord, memread, memwrite, memtoreg, irwrite, regdst, regwrite, alusrca, illegal_op.
REQ-006 SHALL have outputs, 2 bits each: pcsource (00 ALU, 01 ALUOut, 10 jump target); alusrcb (00 B, 01 const 4, 10 signext imm, 11 imm<<2); aluop (00 add, 01 sub, 10 funct, 11 and).
REQ-007 SHALL have outputs: state  4  current state encoding; instr_count  32  count of retired instructions.

Function
REQ-008 SHALL have states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11; 12-15 unused.
REQ-009 SHALL decode all control outputs combinationally from state, opcode and mem_ready (Moore style plus mem_ready qualification); every output not listed for a state is 0.
REQ-010 FETCH: memread=1, alusrcb=01; irwrite=pcwrite=mem_ready; stays in FETCH while mem_ready=0, else moves to DECODE.
REQ-011 DECODE: alusrcb=11 (branch target precompute). Next state by opcode: 000000->EXEC; 100011/101011->MEMADR; 000100/000101->BRANCH; 000010->JUMP; 001000/001100->IEXEC.
REQ-012 DECODE with any other opcode: illegal_op=1 for that single cycle; next state FETCH; instr_count unchanged.
REQ-013 MEMADR: alusrca=1, alusrcb=10; next MEMRD if opcode=100011, else MEMWR.
REQ-014 MEMRD: memread=1, iord=1; held until mem_ready=1, then MEMWB. MEMWB: memtoreg=1, regwrite=1; next FETCH.
REQ-015 MEMWR: memwrite=1, iord=1; held until mem_ready=1, then FETCH.
REQ-016 EXEC: alusrca=1, aluop=10; next RWB. RWB: regdst=1, regwrite=1; next FETCH.
REQ-017 BRANCH: alusrca=1, aluop=01, pcsource=01; pcwritecond_eq=1 if opcode=000100; pcwritecond_ne=1 if opcode=000101; next FETCH.
REQ-018 JUMP: pcwrite=1, pcsource=10; next FETCH.
REQ-019 IEXEC: alusrca=1, alusrcb=10; aluop=00 for addi, 11 for andi; next IWB. IWB: regwrite=1; next FETCH.
REQ-020 Unused encodings SHALL transition to FETCH next cycle with all outputs 0.
REQ-021 Zero-wait latencies SHALL be: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi/andi 4 cycles; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
REQ-022 instr_count SHALL increment by 1 on each clock edge where the current state is MEMWB, MEMWR (with mem_ready=1), RWB, BRANCH, JUMP or IWB; wraps 0xFFFFFFFF->0.
REQ-023 pcwrite and pcwritecond_* SHALL never be asserted in the same cycle; memread and memwrite SHALL never be asserted in the same cycle.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for clk, force state=FETCH and instr_count=0, and force every control output to 0 while reset_n remains low.
REQ-025 Reset asserted mid-instruction SHALL abandon that instruction with no further regwrite/memwrite/pcwrite; the first active edge after release evaluates FETCH.

Verification
REQ-026 Reset, then R-type (000000) with mem_ready=1 -> states 0,1,6,7,0; regwrite=1, regdst=1 only in RWB; instr_count=1.
REQ-027 lw (100011) with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; memread=iord=1 for three cycles; total 7 cycles.
REQ-028 bne (000101) -> states 0,1,8; pcwritecond_ne=1 and pcwritecond_eq=0 in BRANCH; beq -> opposite.
REQ-029 opcode 111111 -> states 0,1,0; illegal_op high exactly one cycle; instr_count unchanged.
REQ-030 Preload 0xFFFFFFFF retirements then j (000010) -> pcwrite=1, pcsource=10 in JUMP; instr_count wraps to 0.
REQ-031 sw with reset_n pulsed low during MEMWR -> memwrite drops asynchronously; state=FETCH; instr_count=0.
